// File: rtl/piso_shift_tx.sv
// piso_shift_tx: valid/ready parallel-load word shifted out one bit per clock with first/last framing
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t         state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]  cnt;
  logic           shifting;
  logic           acc;
  always_comb begin
    shifting   = state == SHIFT;
    load_ready = !shifting || cnt == LAST;
    acc        = load_valid && load_ready;
    sout       = shifting && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    sout_valid = shifting;
    busy       = shifting;
    sout_first = shifting && cnt == '0;
    sout_last  = shifting && cnt == LAST;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (acc) begin
      state <= SHIFT;
      sreg  <= din;
      cnt   <= '0;
    end else if (shifting) begin
      state <= cnt == LAST ? IDLE : SHIFT;
      sreg  <= cnt == LAST ? '0 : (MSB_FIRST ? sreg << 1 : sreg >> 1);
      cnt   <= cnt == LAST ? '0 : cnt + CW'(1);
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: three piso_shift_tx configurations in lockstep against a bit-queue reference model
module tb_piso_shift_tx;
  typedef struct packed {logic b; logic f; logic l;} ent_t;
  logic clk = 0;
  logic rst_n = 0;
  logic lv = 0;
  logic [7:0] din = '0;
  logic r0, s0, v0, f0, l0, b0;
  logic r1, s1, v1, f1, l1, b1;
  logic r2, s2, v2, f2, l2, b2;
  logic [5:0] o0, o1, o2, e0, e1, e2;
  ent_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(0)) d0 (.clk(clk), .rst_n(rst_n), .load_valid(lv), .din(din[3:0]),
    .load_ready(r0), .sout(s0), .sout_valid(v0), .sout_first(f0), .sout_last(l0), .busy(b0));
  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1)) d1 (.clk(clk), .rst_n(rst_n), .load_valid(lv), .din(din[3:0]),
    .load_ready(r1), .sout(s1), .sout_valid(v1), .sout_first(f1), .sout_last(l1), .busy(b1));
  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(0)) d2 (.clk(clk), .rst_n(rst_n), .load_valid(lv), .din(din),
    .load_ready(r2), .sout(s2), .sout_valid(v2), .sout_first(f2), .sout_last(l2), .busy(b2));
  assign o0 = {r0, s0, v0, f0, l0, b0};
  assign o1 = {r1, s1, v1, f1, l1, b1};
  assign o2 = {r2, s2, v2, f2, l2, b2};
  function automatic logic [5:0] expv(input int n, input ent_t h);
    return n == 0 ? 6'b100000 : {n == 1, h.b, 1'b1, h.f, h.l, 1'b1};
  endfunction
  task automatic tick();
    logic a0, a1, a2;
    logic [7:0] w;
    w  = din;
    a0 = rst_n && lv && q0.size() <= 1;
    a1 = rst_n && lv && q1.size() <= 1;
    a2 = rst_n && lv && q2.size() <= 1;
    @(posedge clk);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (q2.size() > 0) void'(q2.pop_front());
      if (a0) for (int i = 0; i < 4; i++) q0.push_back('{b: w[i], f: i == 0, l: i == 3});
      if (a1) for (int i = 0; i < 4; i++) q1.push_back('{b: w[3-i], f: i == 0, l: i == 3});
      if (a2) for (int i = 0; i < 8; i++) q2.push_back('{b: w[i], f: i == 0, l: i == 7});
    end
    @(negedge clk);
    e0 = expv(q0.size(), q0.size() > 0 ? q0[0] : '0);
    e1 = expv(q1.size(), q1.size() > 0 ? q1[0] : '0);
    e2 = expv(q2.size(), q2.size() > 0 ? q2[0] : '0);
  endtask
  task automatic test_reset();
    #1;
    checks += 3;
    if (o0 !== 6'b100000) begin errors++; $display("FAIL reset d0 got %b exp %b", o0, 6'b100000); end
    if (o1 !== 6'b100000) begin errors++; $display("FAIL reset d1 got %b exp %b", o1, 6'b100000); end
    if (o2 !== 6'b100000) begin errors++; $display("FAIL reset d2 got %b exp %b", o2, 6'b100000); end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_single(input logic [7:0] w, input logic [3:0] x0, input logic [3:0] x1, input logic [7:0] x2, input string nm);
    logic [3:0] c0, c1;
    logic [7:0] c2;
    lv = 1;
    din = w;
    tick();
    lv = 0;
    for (int i = 0; i < 10; i++) begin
      din = 8'($urandom);
      checks += 3;
      if (o0 !== e0) begin errors++; $display("FAIL %s d0 cyc %0d got %b exp %b", nm, i, o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL %s d1 cyc %0d got %b exp %b", nm, i, o1, e1); end
      if (o2 !== e2) begin errors++; $display("FAIL %s d2 cyc %0d got %b exp %b", nm, i, o2, e2); end
      if (i < 4) begin c0 = {c0[2:0], s0}; c1 = {c1[2:0], s1}; end
      if (i < 8) c2 = {c2[6:0], s2};
      if (i == 4) begin
        checks++;
        if (o0 !== 6'b100000) begin errors++; $display("FAIL %s d0 idle after word got %b exp %b", nm, o0, 6'b100000); end
      end
      tick();
    end
    checks += 3;
    if (c0 !== x0) begin errors++; $display("FAIL %s d0 bits got %b exp %b", nm, c0, x0); end
    if (c1 !== x1) begin errors++; $display("FAIL %s d1 bits got %b exp %b", nm, c1, x1); end
    if (c2 !== x2) begin errors++; $display("FAIL %s d2 bits got %b exp %b", nm, c2, x2); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] c0, c1;
    int nv;
    nv = 0;
    lv = 1;
    din = 8'h0A;
    tick();
    din = 8'h05;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) lv = 0;
      checks += 3;
      if (o0 !== e0) begin errors++; $display("FAIL b2b d0 cyc %0d got %b exp %b", i, o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL b2b d1 cyc %0d got %b exp %b", i, o1, e1); end
      if (o2 !== e2) begin errors++; $display("FAIL b2b d2 cyc %0d got %b exp %b", i, o2, e2); end
      if (i < 8) begin c0 = {c0[6:0], s0}; c1 = {c1[6:0], s1}; nv += int'(v0); end
      if (i == 4) begin
        checks++;
        if ({f0, l0} !== 2'b10) begin errors++; $display("FAIL b2b second first got %b exp %b", {f0, l0}, 2'b10); end
      end
      tick();
    end
    checks += 3;
    if (c0 !== 8'b01011010) begin errors++; $display("FAIL b2b d0 bits got %b exp %b", c0, 8'b01011010); end
    if (c1 !== 8'b10100101) begin errors++; $display("FAIL b2b d1 bits got %b exp %b", c1, 8'b10100101); end
    if (nv !== 8) begin errors++; $display("FAIL b2b valid cycles got %0d exp %0d", nv, 8); end
  endtask
  task automatic test_ignored_inputs();
    logic [7:0] c0;
    lv = 1;
    din = 8'h0F;
    tick();
    din = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) lv = 0;
      checks += 3;
      if (o0 !== e0) begin errors++; $display("FAIL ignore d0 cyc %0d got %b exp %b", i, o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL ignore d1 cyc %0d got %b exp %b", i, o1, e1); end
      if (o2 !== e2) begin errors++; $display("FAIL ignore d2 cyc %0d got %b exp %b", i, o2, e2); end
      if (i < 8) c0 = {c0[6:0], s0};
      if (i < 3) begin
        checks++;
        if (r0 !== 1'b0) begin errors++; $display("FAIL ignore ready cyc %0d got %b exp %b", i, r0, 1'b0); end
      end
      tick();
    end
    checks++;
    if (c0 !== 8'b11110000) begin errors++; $display("FAIL ignore d0 bits got %b exp %b", c0, 8'b11110000); end
  endtask
  task automatic test_reset_mid_word();
    lv = 1;
    din = 8'h0C;
    tick();
    lv = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks += 3;
    if (o0 !== 6'b100000) begin errors++; $display("FAIL midreset d0 got %b exp %b", o0, 6'b100000); end
    if (o1 !== 6'b100000) begin errors++; $display("FAIL midreset d1 got %b exp %b", o1, 6'b100000); end
    if (o2 !== 6'b100000) begin errors++; $display("FAIL midreset d2 got %b exp %b", o2, 6'b100000); end
    lv = 1;
    din = 8'hFF;
    tick();
    rst_n = 1;
    lv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 3;
      if (o0 !== 6'b100000) begin errors++; $display("FAIL postreset d0 cyc %0d got %b exp %b", i, o0, 6'b100000); end
      if (o1 !== 6'b100000) begin errors++; $display("FAIL postreset d1 cyc %0d got %b exp %b", i, o1, 6'b100000); end
      if (o2 !== 6'b100000) begin errors++; $display("FAIL postreset d2 cyc %0d got %b exp %b", i, o2, 6'b100000); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      lv = $urandom_range(0, 9) < 7;
      din = 8'($urandom);
      if (i >= 390) lv = 0;
      tick();
      checks += 3;
      if (o0 !== e0) begin errors++; $display("FAIL random d0 cyc %0d got %b exp %b", i, o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL random d1 cyc %0d got %b exp %b", i, o1, e1); end
      if (o2 !== e2) begin errors++; $display("FAIL random d2 cyc %0d got %b exp %b", i, o2, e2); end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single(8'h0B, 4'b1101, 4'b1011, 8'b11010000, "single");
    test_single(8'h96, 4'b0110, 4'b0110, 8'b01101001, "w8_96");
    test_back_to_back();
    test_ignored_inputs();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
